// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding, BCD limit and load clamp helper for the MM:SS countdown timer
package timer_pkg;
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_DONE  = 2'd3
   } state_t;
   localparam logic [3:0] BCD_MAX = 4'd9;
   function automatic logic [3:0] bcd_clamp(input logic [3:0] value, input logic [3:0] max);
      return (value > max) ? max : value;
   endfunction
endpackage

// File: rtl/bcd_down_digit.sv
// bcd_down_digit: one BCD down-counting digit that reloads MAX on borrow
//   clock/clrn : clock, async active-low reset (digit clears to 0)
//   ld/ld_val  : synchronous load, overrides dec
//   dec        : decrement this cycle; at 0 the digit reloads MAX
//   digit      : current value
//   is_zero    : digit == 0, feeds the borrow chain in the parent
module bcd_down_digit
   import timer_pkg::*;
#(
   parameter logic [3:0] MAX = BCD_MAX
) (
   input  logic       clock,
   input  logic       clrn,
   input  logic       ld,
   input  logic [3:0] ld_val,
   input  logic       dec,
   output logic [3:0] digit,
   output logic       is_zero
);
   logic [3:0] digit_q, digit_d;
   always_comb digit_d = ld ? ld_val : dec ? ((digit_q == 4'd0) ? MAX : digit_q - 4'd1) : digit_q;
   always_ff @(posedge clock or negedge clrn)
      if (!clrn) digit_q <= 4'd0;
      else digit_q <= digit_d;
   assign digit   = digit_q;
   assign is_zero = (digit_q == 4'd0);
endmodule

// File: rtl/timer_mmss_down.sv
// timer_mmss_down: four-digit BCD MM:SS countdown timer with run control and done pulse
//   clock/clrn        : clock, async active-low reset
//   loadn, data_*     : synchronous active-low load of clamped digits, returns to IDLE
//   enable            : 1-cycle tick strobe, one decrement per sampled high while running
//   start/stop        : run control, stop wins when both are high
//   min_*/sec_*       : current digits
//   zero              : all digits 0 (combinational)
//   running           : state is RUN
//   done              : one-cycle pulse after the 00:01 -> 00:00 tick
module timer_mmss_down
   import timer_pkg::*;
#(
   parameter logic [3:0] SEC_TENS_MAX = 4'd5,
   parameter logic [3:0] MIN_TENS_MAX = 4'd9
) (
   input  logic       clock,
   input  logic       clrn,
   input  logic       loadn,
   input  logic       enable,
   input  logic       start,
   input  logic       stop,
   input  logic [3:0] data_mt,
   input  logic [3:0] data_mo,
   input  logic [3:0] data_st,
   input  logic [3:0] data_so,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       zero,
   output logic       running,
   output logic       done
);
   state_t state_q;
   logic   done_q;
   logic   so_z, st_z, mo_z, mt_z;
   logic   ld, tick, last;
   assign ld = !loadn;
   // load and stop both swallow a same-cycle strobe; zero never coexists with RUN
   assign tick = (state_q == S_RUN) && enable && loadn && !stop;
   assign last = tick && mt_z && mo_z && st_z && (sec_ones == 4'd1);
   bcd_down_digit #(.MAX(BCD_MAX)) u_so (
      .clock(clock), .clrn(clrn), .ld(ld), .ld_val(bcd_clamp(data_so, BCD_MAX)),
      .dec(tick), .digit(sec_ones), .is_zero(so_z));
   bcd_down_digit #(.MAX(SEC_TENS_MAX)) u_st (
      .clock(clock), .clrn(clrn), .ld(ld), .ld_val(bcd_clamp(data_st, SEC_TENS_MAX)),
      .dec(tick && so_z), .digit(sec_tens), .is_zero(st_z));
   bcd_down_digit #(.MAX(BCD_MAX)) u_mo (
      .clock(clock), .clrn(clrn), .ld(ld), .ld_val(bcd_clamp(data_mo, BCD_MAX)),
      .dec(tick && so_z && st_z), .digit(min_ones), .is_zero(mo_z));
   bcd_down_digit #(.MAX(MIN_TENS_MAX)) u_mt (
      .clock(clock), .clrn(clrn), .ld(ld), .ld_val(bcd_clamp(data_mt, MIN_TENS_MAX)),
      .dec(tick && so_z && st_z && mo_z), .digit(min_tens), .is_zero(mt_z));
   assign zero = so_z && st_z && mo_z && mt_z;
   always_ff @(posedge clock or negedge clrn)
      if (!clrn) begin
         state_q <= S_IDLE;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (ld) state_q <= S_IDLE;
         else if (stop) begin
            if (state_q == S_RUN) state_q <= S_PAUSE;
         end else if (start && ((state_q == S_IDLE && !zero) || state_q == S_PAUSE)) state_q <= S_RUN;
         else if (last) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
         end
      end
   assign running = (state_q == S_RUN);
   assign done    = done_q;
endmodule

// File: tb/tb_timer_mmss_down.sv
// tb_timer_mmss_down: directed bench against a seconds-count model of the countdown timer
module tb_timer_mmss_down;
   logic       clock = 1'b0, clrn = 1'b0, loadn = 1'b1, enable = 1'b0, start = 1'b0, stop = 1'b0;
   logic [3:0] data_mt = '0, data_mo = '0, data_st = '0, data_so = '0;
   logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
   logic       zero, running, done;
   int total = 0, bad = 0;
   bit chk_on = 1'b0;
   timer_mmss_down dut (
      .clock(clock), .clrn(clrn), .loadn(loadn), .enable(enable), .start(start), .stop(stop),
      .data_mt(data_mt), .data_mo(data_mo), .data_st(data_st), .data_so(data_so),
      .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
      .zero(zero), .running(running), .done(done));
   always #5 clock = ~clock;
   // model: remaining time as plain seconds, mode 0 idle, 1 run, 2 pause, 3 done
   int m_secs = 0, m_mode = 0;
   bit m_done = 1'b0;
   function automatic int mn(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction
   always @(posedge clock or negedge clrn)
      if (!clrn) begin
         m_secs = 0; m_mode = 0; m_done = 1'b0;
      end else if (!loadn) begin
         m_secs = mn(int'(data_mt), 9) * 600 + mn(int'(data_mo), 9) * 60 + mn(int'(data_st), 5) * 10 + mn(int'(data_so), 9);
         m_mode = 0; m_done = 1'b0;
      end else begin
         m_done = 1'b0;
         if (stop) begin
            if (m_mode == 1) m_mode = 2;
         end else if (start && ((m_mode == 0 && m_secs != 0) || m_mode == 2)) m_mode = 1;
         else if (m_mode == 1 && enable) begin
            m_secs = m_secs - 1;
            if (m_secs == 0) begin m_mode = 3; m_done = 1'b1; end
         end
      end
   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
      end
   endtask
   always @(negedge clock)
      if (chk_on) begin
         chk("min_tens", int'(min_tens), m_secs / 600);
         chk("min_ones", int'(min_ones), (m_secs / 60) % 10);
         chk("sec_tens", int'(sec_tens), (m_secs % 60) / 10);
         chk("sec_ones", int'(sec_ones), m_secs % 10);
         chk("zero", int'(zero), int'(m_secs == 0));
         chk("running", int'(running), int'(m_mode == 1));
         chk("done", int'(done), int'(m_done));
      end
   task automatic cyc();
      @(posedge clock);
      #1;
   endtask
   task automatic load(input logic [3:0] mt, input logic [3:0] mo, input logic [3:0] st, input logic [3:0] so);
      data_mt = mt; data_mo = mo; data_st = st; data_so = so; loadn = 1'b0;
      cyc();
      loadn = 1'b1;
   endtask
   task automatic go();
      start = 1'b1; cyc(); start = 1'b0;
   endtask
   task automatic halt();
      stop = 1'b1; cyc(); stop = 1'b0;
   endtask
   task automatic strobes(input int n);
      enable = 1'b1;
      repeat (n) cyc();
      enable = 1'b0;
   endtask
   task automatic lit(input string name, input int mt, input int mo, input int st, input int so, input int run, input int dn);
      chk({name, ".time"}, int'({min_tens, min_ones, sec_tens, sec_ones}), (mt << 12) | (mo << 8) | (st << 4) | so);
      chk({name, ".running"}, int'(running), run);
      chk({name, ".done"}, int'(done), dn);
   endtask
   initial begin
      #2;
      lit("reset", 0, 0, 0, 0, 0, 0);
      chk("reset.zero", int'(zero), 1);
      chk_on = 1'b1;
      repeat (2) cyc();
      clrn = 1'b1;
      cyc();
      load(4'd0, 4'd1, 4'd3, 4'd0);
      lit("load0130", 0, 1, 3, 0, 0, 0);
      go();
      strobes(89);
      lit("t1_0001", 0, 0, 0, 1, 1, 0);
      strobes(1);
      lit("t1_0000", 0, 0, 0, 0, 0, 1);
      cyc();
      lit("t1_after", 0, 0, 0, 0, 0, 0);
      strobes(5);
      lit("t1_nowrap", 0, 0, 0, 0, 0, 0);
      load(4'd1, 4'd0, 4'd0, 4'd0);
      go();
      strobes(1);
      lit("t2_0959", 0, 9, 5, 9, 1, 0);
      load(4'd0, 4'd0, 4'd1, 4'd0);
      go();
      strobes(1);
      lit("t2_0009", 0, 0, 0, 9, 1, 0);
      load(4'd9, 4'hF, 4'd7, 4'hC);
      lit("t3_clamp", 9, 9, 5, 9, 0, 0);
      load(4'd0, 4'd5, 4'd0, 4'd0);
      go();
      strobes(3);
      halt();
      strobes(5);
      lit("t4_paused", 0, 4, 5, 7, 0, 0);
      go();
      strobes(2);
      lit("t4_0455", 0, 4, 5, 5, 1, 0);
      start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
      lit("t4_both", 0, 4, 5, 5, 0, 0);
      strobes(2);
      lit("t4_hold", 0, 4, 5, 5, 0, 0);
      load(4'd0, 4'd0, 4'd0, 4'd0);
      go();
      strobes(3);
      lit("t5_zero", 0, 0, 0, 0, 0, 0);
      load(4'd0, 4'd2, 4'd2, 4'd0);
      go();
      strobes(3);
      lit("t6_0217", 0, 2, 1, 7, 1, 0);
      enable = 1'b1;
      #2 clrn = 1'b0;
      #1 lit("t6_async", 0, 0, 0, 0, 0, 0);
      enable = 1'b0;
      cyc();
      clrn = 1'b1;
      cyc();
      load(4'd0, 4'd1, 4'd0, 4'd0);
      go();
      strobes(2);
      lit("t6_0058", 0, 0, 5, 8, 1, 0);
      enable = 1'b1;
      load(4'd0, 4'd0, 4'd4, 4'd2);
      enable = 1'b0;
      lit("t6_loadtick", 0, 0, 4, 2, 0, 0);
      repeat (2) cyc();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
